// File: rtl/rtype_issue_ctrl_pkg.sv
// Shared definitions for the R-type issue controller:
// instruction fields, function codes, FSM states and decode helpers.
package rtype_issue_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic is_shift(logic [5:0] f);
    return (f == FUNCT_SLL) || (f == FUNCT_SRL);
  endfunction

  function automatic logic is_arith(logic [5:0] f);
    return (f == FUNCT_ADD) || (f == FUNCT_SUB) ||
           (f == FUNCT_AND) || (f == FUNCT_OR);
  endfunction

  function automatic logic is_illegal(instr_t i, logic strict);
    logic bad;
    bad = 1'b1;
    if (i.opcode == OPC_RTYPE) begin
      unique case (1'b1)
        is_arith(i.funct): bad = strict && (i.shamt != '0);
        is_shift(i.funct): bad = strict && (i.rs != '0);
        default:           bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/rtype_issue_ctrl_rf.sv
// 32x32 register file: three async read ports, one sync write
// port, async clear. R0 is hardwired to zero.
module rf_2r1w (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic [4:0]  raddr_c_i,
  output logic [31:0] rdata_c_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  assign rdata_c_o = (raddr_c_i == '0) ? '0 : mem_q[raddr_c_i];

endmodule

// File: rtl/rtype_issue_ctrl.sv
// R-type issue controller: accepts one instruction at a time,
// drives the external ALU and writes the result back to rd.
module rtype_issue_ctrl
  import rtype_issue_ctrl_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  output logic        done_valid,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        done_err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  state_e      state_q, state_d;
  instr_t      instr_q;
  logic [31:0] op1_q, op2_q;
  logic [5:0]  funct_q;
  logic        err_q;
  logic [4:0]  drd_q;
  logic [31:0] ddata_q;
  logic        derr_q;

  logic [31:0] rs_val, rt_val;
  logic        bad;
  logic        rf_we;

  assign bad = is_illegal(instr_q, STRICT_DECODE);
  assign rf_we = (state_q == S_WB) && !err_q;

  rf_2r1w u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (instr_q.rd),
    .wdata_i   (ddata_q),
    .raddr_a_i (instr_q.rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (instr_q.rt),
    .rdata_b_o (rt_val),
    .raddr_c_i (dbg_addr),
    .rdata_c_o (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      funct_q <= FUNCT_ADD;
      err_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid) instr_q <= in_instr;
      if (state_q == S_DECODE) begin
        err_q <= bad;
        if (!bad) begin
          op1_q   <= is_shift(instr_q.funct) ? rt_val : rs_val;
          op2_q   <= is_shift(instr_q.funct) ?
                     {27'b0, instr_q.shamt} : rt_val;
          funct_q <= instr_q.funct;
        end
      end
    end
  end

  // The done registers double as the result register: loaded
  // at the end of EXEC, shown in WB, held until the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drd_q   <= '0;
      ddata_q <= '0;
      derr_q  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      drd_q   <= instr_q.rd;
      derr_q  <= err_q;
      ddata_q <= err_q ? '0 : alu_result;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign done_valid = (state_q == S_WB);
  assign done_rd    = drd_q;
  assign done_data  = ddata_q;
  assign done_err   = derr_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_funct  = funct_q;

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Bench for rtype_issue_ctrl with a behavioural ALU and an
// array-based architectural model of the register file.
module tb_rtype_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [5:0]  alu_funct;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        done_err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        inj_en;
  logic [31:0] inj_val;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_op1, m_op2;
  logic [5:0]  m_fn;

  rtype_issue_ctrl #(.STRICT_DECODE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_funct  (alu_funct),
    .alu_result (alu_result),
    .done_valid (done_valid),
    .done_rd    (done_rd),
    .done_data  (done_data),
    .done_err   (done_err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; injection lets the bench seed nonzero values.
  always_comb begin
    alu_result = '0;
    if (inj_en) alu_result = inj_val;
    else begin
      case (alu_funct)
        6'b100000: alu_result = alu_op1 + alu_op2;
        6'b100010: alu_result = alu_op1 - alu_op2;
        6'b100100: alu_result = alu_op1 & alu_op2;
        6'b100101: alu_result = alu_op1 | alu_op2;
        6'b000000: alu_result = alu_op1 << alu_op2[4:0];
        6'b000010: alu_result = alu_op1 >> alu_op2[4:0];
        default:   alu_result = '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rs,
      input int rt, input int rd, input int sh, input int fn);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_op1 = '0;
    m_op2 = '0;
    m_fn  = 6'h20;
  endtask

  task automatic dbg_sweep(input string tag);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      check(tag, dbg_data, m_rf[a]);
    end
  endtask

  // Issue one instruction from an IDLE negedge and check it.
  task automatic run(input logic [31:0] ins, input bit inj,
                     input logic [31:0] iv);
    int op, rs, rt, rd, sh, fn, lat, g;
    bit arith, shift, err;
    logic [31:0] a, b, res;
    op = int'(ins[31:26]); rs = int'(ins[25:21]);
    rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    sh = int'(ins[10:6]);  fn = int'(ins[5:0]);
    arith = (fn == 32) || (fn == 34) || (fn == 36) || (fn == 37);
    shift = (fn == 0) || (fn == 2);
    err = (op != 0) || !(arith || shift) ||
          (arith && sh != 0) || (shift && rs != 0);
    a = shift ? m_rf[rt] : m_rf[rs];
    b = shift ? 32'(sh) : m_rf[rt];
    case (fn)
      32: res = a + b;
      34: res = a - b;
      36: res = a & b;
      37: res = a | b;
      0:  res = a * (32'd1 << sh);
      2:  res = a / (32'd1 << sh);
      default: res = '0;
    endcase
    if (inj) res = iv;
    if (err) res = '0;
    else begin
      m_op1 = a; m_op2 = b; m_fn = fn[5:0];
    end
    g = 0;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    check("ready_wait", 32'(in_ready), 32'd1);
    inj_en = inj; inj_val = iv;
    in_valid = 1'b1; in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 8) begin @(negedge clk); lat++; end
    check("latency", 32'(lat), 32'd3);
    check("done_rd", 32'(done_rd), 32'(rd));
    check("done_err", 32'(done_err), 32'(err));
    check("done_data", done_data, res);
    check("alu_op1", alu_op1, m_op1);
    check("alu_op2", alu_op2, m_op2);
    check("alu_funct", 32'(alu_funct), 32'(m_fn));
    if (!err && rd != 0) m_rf[rd] = res;
    @(negedge clk);
    inj_en = 1'b0;
    check("pulse", 32'(done_valid), 32'd0);
    check("hold_data", done_data, res);
    dbg_addr = rd[4:0]; #1;
    check("dbg_rd", dbg_data, m_rf[rd]);
    g = $urandom_range(0, 31);
    dbg_addr = g[4:0]; #1;
    check("dbg_rand", dbg_data, m_rf[g]);
  endtask

  task automatic preload(input int r, input logic [31:0] v);
    run(mk(0, 0, 0, r, 0, 32), 1'b1, v);
  endtask

  int fns [6] = '{32, 34, 36, 37, 0, 2};

  initial begin
    int nr, nd, op, rs, sh, fn;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    dbg_addr = '0; inj_en = 1'b0; inj_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_funct", 32'(alu_funct), 32'h20);
    check("rst_op1", alu_op1, 32'd0);
    check("rst_data", done_data, 32'd0);
    dbg_sweep("rst_dbg");

    preload(1, 32'h0A);
    preload(2, 32'h05);
    preload(5, 32'h1A);
    run(mk(0, 1, 2, 3, 0, 32), 1'b0, '0);
    check("add_r3", m_rf[3], 32'h0F);
    run(mk(0, 1, 5, 4, 0, 34), 1'b0, '0);
    check("sub_r4", m_rf[4], 32'hFFFFFFF0);
    run(mk(0, 1, 2, 6, 0, 36), 1'b0, '0);
    run(mk(0, 1, 2, 7, 0, 37), 1'b0, '0);
    run(mk(0, 0, 1, 8, 6, 0), 1'b0, '0);
    check("sll_r8", m_rf[8], 32'h280);
    run(mk(0, 0, 1, 9, 2, 2), 1'b0, '0);
    check("srl_r9", m_rf[9], 32'h2);
    run(mk(0, 1, 1, 11, 2, 2), 1'b0, '0);
    run(mk(0, 1, 2, 0, 0, 32), 1'b0, '0);
    run(mk(35, 1, 2, 12, 0, 32), 1'b0, '0);
    run(mk(0, 1, 2, 13, 3, 32), 1'b0, '0);
    dbg_sweep("dir_dbg");

    // in_valid held high: one accept every four cycles
    nr = 0; nd = 0;
    in_valid = 1'b1; in_instr = mk(0, 1, 2, 10, 0, 32);
    for (int t = 0; t < 16; t++) begin
      if (in_ready) nr++;
      if (done_valid) nd++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("held_ready", 32'(nr), 32'd4);
    check("held_done", 32'(nd), 32'd4);
    m_rf[10] = m_rf[1] + m_rf[2];
    m_op1 = m_rf[1]; m_op2 = m_rf[2]; m_fn = 6'h20;
    dbg_addr = 5'd10; #1;
    check("held_r10", dbg_data, m_rf[10]);

    // reset while in EXEC
    in_valid = 1'b1; in_instr = mk(0, 1, 2, 14, 0, 32);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    nd = 0;
    repeat (3) begin
      if (done_valid) nd++;
      @(negedge clk);
    end
    check("rst_mid_done", 32'(nd), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_funct", 32'(alu_funct), 32'h20);
    dbg_sweep("rst_mid_dbg");

    // randomized traffic
    for (int r = 1; r < 8; r++) preload(r, $urandom);
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : 0;
      fn = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)
                                       : fns[$urandom_range(0, 5)];
      sh = ($urandom_range(0, 3) == 0 || fn < 32) ?
           $urandom_range(0, 31) : 0;
      rs = (fn < 32 && $urandom_range(0, 3) != 0) ? 0
                                                 : $urandom_range(0, 31);
      run(mk(op, rs, $urandom_range(0, 31), $urandom_range(0, 31),
             sh, fn), 1'b0, '0);
    end
    dbg_sweep("rand_dbg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
